ecpeta_pipe: RTL and testbench

Pipelined, parametrised successor to the fixed 16-bit/k=11 ECPETA approximate adder. It adds two N-bit operands with a runtime-selectable approximate lower part of 0..K bits; k_sel=0 gives an exact add. Operands move through a 2-stage valid/ready pipeline, so the block drops into streaming datapaths. An optional error-statistics unit compares every result against the exact sum.

---
 rtl/ecpeta_pipe.sv | 135 +++++++++++++
 tb/tb_ecpeta_pipe.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ecpeta_pipe.sv
// ECPETA approximate adder, 2-stage valid/ready pipeline with runtime approximate width.
// Define ECPETA_ERRSTAT_EN to build the error-statistics unit (err_cnt/err_max).
module ecpeta_pipe #(
  parameter int N  = 16,
  parameter int K  = 11,
  parameter int KW = $clog2(K + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  A,
  input  logic [N-1:0]  B,
  input  logic [KW-1:0] k_sel,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  sum,
  output logic          cout,
  input  logic          stat_clr,
  output logic [31:0]   err_cnt,
  output logic [N:0]    err_max
);

  logic          adv;
  logic [KW-1:0] ke_d, ke_q;
  logic [N-1:0]  lo_d, lo_q;
  logic          g_d, g_q;
  logic [N-1:0]  a_q, b_q;
  logic          s1_valid_q;
  logic [N:0]    upper_d, res_d;
  logic [N-1:0]  sum_q;
  logic          cout_q;
  logic          out_valid_q;
  int unsigned   kei;

  assign adv       = !out_valid_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

  // Stage 1 input side: clamp width, OR the lower bits, half-add the top approximate bit.
  always_comb begin
    ke_d = (k_sel > KW'(K)) ? KW'(K) : k_sel;
    kei  = 32'(ke_d);
    lo_d = '0;
    g_d  = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (i + 1 < kei) begin
        lo_d[i] = A[i] | B[i];
      end else if (i + 1 == kei) begin
        lo_d[i] = A[i] ^ B[i];
        g_d     = A[i] & B[i];
      end
    end
  end

  // Stage 2 input side: exact add of the upper slices, realigned and merged with the lower part.
  always_comb begin
    upper_d = ({1'b0, a_q >> ke_q} + {1'b0, b_q >> ke_q} + {{N{1'b0}}, g_q}) << ke_q;
    res_d   = upper_d | {1'b0, lo_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      ke_q        <= '0;
      lo_q        <= '0;
      g_q         <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
    end else if (adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        a_q  <= A;
        b_q  <= B;
        ke_q <= ke_d;
        lo_q <= lo_d;
        g_q  <= g_d;
      end
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        {cout_q, sum_q} <= res_d;
      end
    end
  end

`ifdef ECPETA_ERRSTAT_EN
  logic [N:0]  exact_q;
  logic [N:0]  approx;
  logic [N:0]  diff;
  logic [31:0] err_cnt_q;
  logic [N:0]  err_max_q;
  logic        xfer;

  assign xfer    = out_valid_q && out_ready;
  assign approx  = {cout_q, sum_q};
  assign diff    = (exact_q >= approx) ? (exact_q - approx) : (approx - exact_q);
  assign err_cnt = err_cnt_q;
  assign err_max = err_max_q;

  // Exact sum travels alongside the approximate result so the compare happens at transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exact_q   <= '0;
      err_cnt_q <= '0;
      err_max_q <= '0;
    end else begin
      if (adv && s1_valid_q) begin
        exact_q <= {1'b0, a_q} + {1'b0, b_q};
      end
      if (stat_clr) begin
        err_cnt_q <= '0;
        err_max_q <= '0;
      end else if (xfer && (approx != exact_q)) begin
        if (err_cnt_q != '1) begin
          err_cnt_q <= err_cnt_q + 32'd1;
        end
        if (diff > err_max_q) begin
          err_max_q <= diff;
        end
      end
    end
  end
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign err_cnt         = '0;
  assign err_max         = '0;
`endif

endmodule

// File: tb/tb_ecpeta_pipe.sv
// Directed self-checking bench for ecpeta_pipe; expected sums are hand-computed.
// Statistics expectations follow ECPETA_ERRSTAT_EN (zero when the unit is not built).
module tb_ecpeta_pipe;
  localparam int N  = 16;
  localparam int K  = 11;
  localparam int KW = 4;

`ifdef ECPETA_ERRSTAT_EN
  localparam bit ES = 1'b1;
`else
  localparam bit ES = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  A;
  logic [N-1:0]  B;
  logic [KW-1:0] k_sel;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  sum;
  logic          cout;
  logic          stat_clr;
  logic [31:0]   err_cnt;
  logic [N:0]    err_max;

  int vectors     = 0;
  int miscompares = 0;

  ecpeta_pipe #(.N(N), .K(K), .KW(KW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .k_sel    (k_sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .stat_clr (stat_clr),
    .err_cnt  (err_cnt),
    .err_max  (err_max)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] es(input logic [63:0] v);
    return ES ? v : 64'd0;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Entered and left at posedge+1; beat sampled at the first edge, result visible after the second.
  task automatic do_beat(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] k, input logic [16:0] exp);
    in_valid  = 1'b1;
    A         = a;
    B         = b;
    k_sel     = k;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_lat"}, 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check({tag, "_vld"}, 64'(out_valid), 64'd1);
    check({tag, "_res"}, 64'({cout, sum}), 64'(exp));
    @(posedge clk); #1;
  endtask

  logic [15:0] sa [8];
  logic [15:0] sb [8];
  logic [3:0]  sk [8];
  logic [16:0] se [8];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int in_idx;
    int out_idx;

    rst = 1'b0; in_valid = 1'b0; A = '0; B = '0; k_sel = '0;
    out_ready = 1'b0; stat_clr = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_vld",  64'(out_valid), 64'd0);
    check("rst_res",  64'({cout, sum}), 64'd0);
    check("rst_cnt",  64'(err_cnt), 64'd0);
    check("rst_max",  64'(err_max), 64'd0);
    check("rst_rdy",  64'(in_ready), 64'd1);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    do_beat("t1", 16'h1234, 16'h5678, 4'd11, 17'h0667C);
    check("t1_cnt", 64'(err_cnt), es(64'd1));
    check("t1_max", 64'(err_max), es(64'h230));
    do_beat("t2", 16'hFFFF, 16'h0001, 4'd11, 17'h0FFFF);
    check("t2_cnt", 64'(err_cnt), es(64'd2));
    do_beat("t3", 16'hFFFF, 16'h0001, 4'd0, 17'h10000);
    check("t3_noinc", 64'(err_cnt), es(64'd2));
    do_beat("t4", 16'h0400, 16'h0400, 4'd11, 17'h00800);
    do_beat("t5", 16'h0400, 16'h0400, 4'd15, 17'h00800);
    check("t5_cnt", 64'(err_cnt), es(64'd2));
    check("t5_max", 64'(err_max), es(64'h230));

    sa[0] = 16'h0001; sb[0] = 16'h0002; sk[0] = 4'd0;  se[0] = 17'h00003;
    sa[1] = 16'h1234; sb[1] = 16'h5678; sk[1] = 4'd11; se[1] = 17'h0667C;
    sa[2] = 16'hFFFF; sb[2] = 16'h0001; sk[2] = 4'd0;  se[2] = 17'h10000;
    sa[3] = 16'hFFFF; sb[3] = 16'h0001; sk[3] = 4'd11; se[3] = 17'h0FFFF;
    sa[4] = 16'h0400; sb[4] = 16'h0400; sk[4] = 4'd11; se[4] = 17'h00800;
    sa[5] = 16'h00FF; sb[5] = 16'h0001; sk[5] = 4'd4;  se[5] = 17'h000FF;
    sa[6] = 16'h8000; sb[6] = 16'h8000; sk[6] = 4'd0;  se[6] = 17'h10000;
    sa[7] = 16'h0F0F; sb[7] = 16'h0101; sk[7] = 4'd8;  se[7] = 17'h0100F;

    in_idx  = 0;
    out_idx = 0;
    for (int cyc = 0; cyc < 40 && out_idx < 8; cyc++) begin
      out_ready = !(cyc >= 4 && cyc <= 6);
      if (in_idx < 8) begin
        in_valid = 1'b1;
        A        = sa[in_idx];
        B        = sb[in_idx];
        k_sel    = sk[in_idx];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid) begin
        check($sformatf("stream_res%0d", out_idx), 64'({cout, sum}), 64'(se[out_idx]));
        if (out_ready) out_idx++;
      end
      if (!out_ready) check($sformatf("stall_rdy%0d", cyc), 64'(in_ready), 64'd0);
      if (in_valid && in_ready) in_idx++;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_cnt",   64'(out_idx), 64'd8);
    check("stream_drain", 64'(out_valid), 64'd0);
    check("stream_errcnt", 64'(err_cnt), es(64'd6));
    check("stream_errmax", 64'(err_max), es(64'h230));

    in_valid = 1'b1; A = 16'h1234; B = 16'h5678; k_sel = 4'd11; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("clr_vld", 64'(out_valid), 64'd1);
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    check("clr_cnt", 64'(err_cnt), 64'd0);
    check("clr_max", 64'(err_max), 64'd0);
    check("clr_xfer", 64'(out_valid), 64'd0);
    do_beat("t6", 16'hFFFF, 16'h0001, 4'd11, 17'h0FFFF);
    check("t6_cnt", 64'(err_cnt), es(64'd1));
    check("t6_max", 64'(err_max), es(64'd1));

    in_valid = 1'b1; A = 16'h0101; B = 16'h0202; k_sel = 4'd0; out_ready = 1'b1;
    @(posedge clk); #1;
    A = 16'h0303; B = 16'h0404;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("rst_pre", 64'(out_valid), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("arst_vld", 64'(out_valid), 64'd0);
    check("arst_res", 64'({cout, sum}), 64'd0);
    check("arst_cnt", 64'(err_cnt), 64'd0);
    check("arst_max", 64'(err_max), 64'd0);
    @(posedge clk); @(posedge clk); #3;
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check($sformatf("rst_stale%0d", c), 64'(out_valid), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
